// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, opcodes,
// datapath select encodings and the registered control bundle.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_LUI,
    CLS_AUIPC
  } inst_cls_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_ADD = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_U = 2'b10
  } imm_sel_t;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_READ  = 2'b10
  } mem_rw_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic     mem_req;
    mem_rw_t  mem_rw;
    logic     reg_wen;
    imm_sel_t imm_sel;
    logic     bsel;
    alu_op_t  alu_sel;
    logic     wb_sel;
    logic     auipc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mem_req: 1'b0, mem_rw: MEM_IDLE, reg_wen: 1'b0,
                                  imm_sel: IMM_I, bsel: 1'b0, alu_sel: ALU_ADD,
                                  wb_sel: 1'b1, auipc_sel: 1'b0};

  localparam ctrl_t CTRL_FETCH = '{mem_req: 1'b1, mem_rw: MEM_READ, reg_wen: 1'b0,
                                   imm_sel: IMM_I, bsel: 1'b0, alu_sel: ALU_ADD,
                                   wb_sel: 1'b1, auipc_sel: 1'b0};

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction, shared memory handshake
// and all datapath select/enable lines.
interface multicycle_controller_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        MemReq;
  logic [1:0]  MemRW;
  logic        PCWEn;
  logic        IRWEn;
  logic [1:0]  ImmSel;
  logic        RegWEn;
  logic        Bsel;
  logic [2:0]  ALUSel;
  logic        WBSel;
  logic        AuipcSel;
  logic        Illegal;
  logic        BusErr;
  logic [2:0]  state;

  modport master (
    input  inst, mem_ready,
    output MemReq, MemRW, PCWEn, IRWEn, ImmSel, RegWEn, Bsel, ALUSel,
           WBSel, AuipcSel, Illegal, BusErr, state
  );

  modport slave (
    output inst, mem_ready,
    input  MemReq, MemRW, PCWEn, IRWEn, ImmSel, RegWEn, Bsel, ALUSel,
           WBSel, AuipcSel, Illegal, BusErr, state
  );
endinterface

// File: rtl/inst_classifier.sv
// Combinational RV32I-subset decode: instruction class, ALU op and illegal flag.
module inst_classifier
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alt,
  output inst_cls_t  cls,
  output alu_op_t    alu_sel,
  output logic       illegal
);

  alu_op_t alu_f3;
  logic    alu_fmt_bad;

  always_comb begin
    case (funct3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  // funct3 checks only apply to ALU formats; for lui/auipc those bits are immediate
  assign alu_fmt_bad = (funct3 == 3'b011) || (funct3 == 3'b101 && alt);

  always_comb begin
    cls     = CLS_R;
    alu_sel = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cls     = CLS_R;
        alu_sel = (funct3 == 3'b000 && alt) ? ALU_SUB : alu_f3;
        illegal = alu_fmt_bad;
      end
      OP_IALU: begin
        cls     = CLS_IALU;
        alu_sel = alu_f3;
        illegal = alu_fmt_bad;
      end
      OP_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (funct3 != 3'b010);
      end
      OP_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 != 3'b010);
      end
      OP_LUI:   cls = CLS_LUI;
      OP_AUIPC: cls = CLS_AUIPC;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port for fetch and load/store.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_t            state_q;
  ctrl_t             ctrl;
  inst_cls_t         cls_q;
  logic              rd_nz;
  logic              illegal_q;
  logic              bus_err_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_hit;
  logic              fetch_hit;

  inst_cls_t dec_cls;
  alu_op_t   dec_alu;
  logic      dec_illegal;

  inst_classifier u_classifier (
    .opcode  (bus.inst[6:0]),
    .funct3  (bus.inst[14:12]),
    .alt     (bus.inst[30]),
    .cls     (dec_cls),
    .alu_sel (dec_alu),
    .illegal (dec_illegal)
  );

  assign wait_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  // IR/PC capture must coincide with the memory's ready cycle, so these two
  // enables combine the registered fetch request with mem_ready.
  assign fetch_hit = (state_q == ST_FETCH) && ctrl.mem_req && bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ctrl      <= CTRL_IDLE;
      cls_q     <= CLS_R;
      rd_nz     <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state_q)
        ST_FETCH, ST_MEM: begin
          if (!ctrl.mem_req) begin
            // first cycle after reset: raise the fetch request
            ctrl     <= CTRL_FETCH;
            wait_cnt <= '0;
          end else if (bus.mem_ready) begin
            if (state_q == ST_FETCH) begin
              state_q <= ST_DECODE;
              ctrl    <= CTRL_IDLE;
            end else if (cls_q == CLS_STORE) begin
              state_q  <= ST_FETCH;
              ctrl     <= CTRL_FETCH;
              wait_cnt <= '0;
            end else begin
              state_q      <= ST_WB;
              ctrl.mem_req <= 1'b0;
              ctrl.mem_rw  <= MEM_IDLE;
              ctrl.reg_wen <= rd_nz;
              ctrl.wb_sel  <= 1'b0;
            end
          end else if (wait_hit) begin
            state_q   <= ST_TRAP;
            ctrl      <= CTRL_IDLE;
            bus_err_q <= 1'b1;
          end else if (MEM_WAIT_MAX != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state_q   <= ST_TRAP;
            ctrl      <= CTRL_IDLE;
            illegal_q <= 1'b1;
          end else begin
            state_q        <= ST_EXEC;
            cls_q          <= dec_cls;
            rd_nz          <= |bus.inst[11:7];
            ctrl.alu_sel   <= dec_alu;
            ctrl.bsel      <= (dec_cls != CLS_R);
            ctrl.imm_sel   <= (dec_cls == CLS_STORE) ? IMM_S :
                              (dec_cls == CLS_LUI || dec_cls == CLS_AUIPC) ? IMM_U : IMM_I;
            ctrl.auipc_sel <= (dec_cls == CLS_LUI || dec_cls == CLS_AUIPC);
          end
        end
        ST_EXEC: begin
          if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
            state_q      <= ST_MEM;
            ctrl.mem_req <= 1'b1;
            ctrl.mem_rw  <= (cls_q == CLS_STORE) ? MEM_WRITE : MEM_READ;
            wait_cnt     <= '0;
          end else begin
            state_q      <= ST_WB;
            ctrl.reg_wen <= rd_nz;
            ctrl.wb_sel  <= 1'b1;
          end
        end
        ST_WB: begin
          state_q  <= ST_FETCH;
          ctrl     <= CTRL_FETCH;
          wait_cnt <= '0;
        end
        default: begin
          state_q <= ST_TRAP;
          ctrl    <= CTRL_IDLE;
        end
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  logic retire;
  assign retire = (state_q == ST_WB) ||
                  (state_q == ST_MEM && cls_q == CLS_STORE && ctrl.mem_req && bus.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`endif

  assign bus.MemReq   = ctrl.mem_req;
  assign bus.MemRW    = ctrl.mem_rw;
  assign bus.RegWEn   = ctrl.reg_wen;
  assign bus.ImmSel   = ctrl.imm_sel;
  assign bus.Bsel     = ctrl.bsel;
  assign bus.ALUSel   = ctrl.alu_sel;
  assign bus.WBSel    = ctrl.wb_sel;
  assign bus.AuipcSel = ctrl.auipc_sel;
  assign bus.IRWEn    = fetch_hit;
  assign bus.PCWEn    = fetch_hit;
  assign bus.Illegal  = illegal_q;
  assign bus.BusErr   = bus_err_q;
  assign bus.state    = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I subset datapath: FETCH/DECODE/EXEC/MEM/WB FSM driving the existing datapath selects (ImmSel, RegWEn, Bsel, ALUSel, MemRW, WBSel, AuipcSel) plus PC/IR write enables and a shared instruction/data memory request handshake. Replaces the single-cycle combinational controller so one memory port serves both fetch and load/store.

Parameters:
MEM_WAIT_MAX, 0, cycles to wait for mem_ready before bus-error trap; 0 = wait forever
CNT_W, 32, width of retired-instruction counter (optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory accepts/completes current request this cycle
MemReq  out  1  memory request valid
MemRW  out  2  10 read, 01 write, 00 idle
PCWEn  out  1  PC <= PC+4
IRWEn  out  1  IR <= memory read data
ImmSel  out  2  00 I, 01 S, 10 U
RegWEn  out  1  register file write
Bsel  out  1  1 = immediate on ALU B
ALUSel  out  3  ALU op (package encoding, 101 = add)
WBSel  out  1  0 = memory data, 1 = ALU result
AuipcSel  out  1  1 = U-type A-operand select
Illegal  out  1  sticky illegal-instruction flag
BusErr  out  1  sticky memory-timeout flag
state  out  3  current FSM state (debug)

Behaviour:
- Reset (async, rst_n low): state=FETCH; MemReq 0, MemRW 00, PCWEn 0, IRWEn 0, RegWEn 0, ImmSel 00, Bsel 0, ALUSel 101, WBSel 1, AuipcSel 0, Illegal 0, BusErr 0. Reset mid-instruction abandons it; no write enable may glitch high.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Moore outputs from state + class/funct registers captured in DECODE; no inst->output combinational path outside DECODE.
- FETCH: MemReq=1, MemRW=10. On mem_ready: IRWEn=1 and PCWEn=1 for that single cycle, -> DECODE; else hold, all requests stable.
- DECODE (1 cycle): classify opcode: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 0110111 lui, 0010111 auipc. Anything else, load/store funct3!=010, funct3=011, or funct3=101 with inst[30]=1 -> TRAP. Else -> EXEC.
- ALUSel: funct3 000 add (101), or sub (110) when R and inst[30]=1; 111 and(000); 110 or(001); 100 xor(010); 001 sll(011); 101 srl(100); 010 slt(111). Load/store/lui/auipc force add.
- EXEC: Bsel=1 except R; ImmSel I for I-ALU/load, S for store, U for lui/auipc; AuipcSel=1 for lui/auipc. Load/store -> MEM; others -> WB.
- MEM: MemReq=1, MemRW=10 load / 01 store, EXEC selects held. On mem_ready: store -> FETCH (retires), load -> WB.
- WB: RegWEn=1 for exactly one cycle unless rd (inst[11:7])==0; WBSel=0 for load else 1; -> FETCH.
- Latency with zero-wait memory: R/I/lui/auipc/store 4 cycles, load 5.
- mem_ready outside FETCH/MEM ignored.
- Timeout: MEM_WAIT_MAX>0 -> wait counter clears on FETCH/MEM entry, increments each unready cycle; reaching MEM_WAIT_MAX -> TRAP, BusErr=1.
- TRAP: absorbing until reset; all enables 0, MemReq 0; Illegal or BusErr held 1.

Optional Feature:
RETIRE_CNT_EN: defined -> extra output instret [CNT_W-1:0], reset 0, +1 on cycle leaving WB or MEM-store toward FETCH, wraps at 2^CNT_W-1 -> 0. Undefined -> port and counter absent; all other behaviour identical.

Decomposition:
Package rv_ctrl_pkg: state encodings, opcode constants, ImmSel/MemRW/ALUSel encodings, instruction-class enum. Sub-module inst_classifier (combinational opcode/funct -> class, ALUSel, illegal) instantiated for DECODE.

Test Plan:
- 0x00100133 (add x2,x0,x1), mem_ready=1 -> FETCH,DECODE,EXEC,WB; WB: RegWEn 1, WBSel 1, ALUSel 101, Bsel 0; back in FETCH on cycle 5.
- 0x00812703 (lw x14,8(x2)) -> MEM: MemRW 10, ImmSel 00, Bsel 1; WB: RegWEn 1, WBSel 0; 5 cycles.
- 0x00E12423 (sw x14,8(x2)) with mem_ready low 3 cycles in MEM -> MemRW 01 held 4 cycles, ImmSel 01, RegWEn never 1.
- 0x00039037 (lui x0) -> ImmSel 10, AuipcSel 1, RegWEn stays 0 (rd=x0); 0x00A08213 (addi x4,x1,10) -> RegWEn 1, Bsel 1.
- 0xFFFFFFFF -> TRAP after DECODE, Illegal 1; MEM_WAIT_MAX=4, mem_ready=0 in FETCH -> TRAP, BusErr 1 after 4 cycles; rst_n pulse -> all outputs reset values.
- RETIRE_CNT_EN: 3 instructions -> instret=3; reset mid-load -> instret 0, no RegWEn.
